apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- APB4 completer (slave) that sits directly downstream of the team's APB master and terminates its PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB bus.
- Returns PREADY, PRDATA and PSLVERR from a register-based word memory.
- Programmable wait-state insertion, byte-strobe writes and error responses, so the master's wait, strobe and error paths are all exercised.

Parameters:
- ADDR_WIDTH, 8, PADDR width (byte address).
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- DEPTH, 32, number of DATA_WIDTH words; valid word indices are 0..DEPTH-1.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  DATA_WIDTH/8  write byte strobes.
- wait_cfg  input  4  wait states for the next transfer; sampled in the setup phase.
- PREADY  output  1  transfer completes this cycle (registered).
- PRDATA  output  DATA_WIDTH  read data; valid when PREADY=1 and PWRITE=0 (registered).
- PSLVERR  output  1  error response; valid only when PREADY=1 (registered).

Behaviour:
- Interface: one clock PCLK; reset PRESET is synchronous and active-high.
- Reset: on any edge with PRESET=1:
  - FSM goes to IDLE; PREADY=0, PSLVERR=0, PRDATA=0.
  - Wait counter = 0; all memory words cleared to 0.
  - A transfer in progress is abandoned and no memory write occurs.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Edge with PSEL=1, PENABLE=0 (setup) → ACCESS.
  - On that edge, latch PADDR, PWRITE, PWDATA and PSTRB, and load cnt=wait_cfg.
  - On the same edge, set PREADY=(wait_cfg==0).
- IDLE protocol violation: edge with PSEL=1, PENABLE=1 and no preceding setup → DONE with PREADY=1, PSLVERR=1, PRDATA=0, no write.
- ACCESS:
  - Each edge with PSEL=1, PENABLE=1, PREADY=0: cnt decrements; PREADY <= (cnt==1).
  - Wait latency: PREADY is high in access cycle wait_cfg+1, i.e. exactly wait_cfg wait cycles.
  - When PREADY is being set to 1, PSLVERR and PRDATA are loaded in the same edge (see error rules).
  - Edge with PSEL=1, PENABLE=1, PREADY=1: transfer completes.
    - Writes commit to memory on this edge, byte lanes gated by latched PSTRB.
    - PREADY <= 0, PSLVERR <= 0, PRDATA <= 0; FSM → IDLE.
  - PSEL=0 while in ACCESS (master abort): → IDLE, PREADY=0, no write.
- DONE: next edge clears PREADY, PSLVERR and PRDATA and returns to IDLE.
- Back-to-back: a setup phase on the cycle after completion is accepted normally, with no idle cycle required.
- Address decode:
  - Word index = PADDR >> log2(DATA_WIDTH/8).
  - Error if PADDR low bits are nonzero (misaligned) or index >= DEPTH.
- On error:
  - PSLVERR=1 with PREADY, PRDATA=0; the write is suppressed.
  - Wait states are still honoured.
- Reads: PRDATA = mem[index] as of the edge setting PREADY. PSTRB is ignored on reads.
- Writes:
  - PSTRB=0 write → no memory change, PSLVERR=0.
  - The address, write data and strobes used are those latched in setup; mid-transfer changes on the bus are ignored.

Optional Feature:
- Macro APB_SLV_STATS_EN.
- When defined, add outputs wr_cnt, rd_cnt and err_cnt (16 bits each).
  - Each increments on the completion edge of a successful write, a successful read, or any PSLVERR=1 transfer respectively.
  - Counters saturate at 16'hFFFF and clear on PRESET.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Zero-wait write then read: wait_cfg=0; write PADDR=8'h04, PWDATA=32'hDEADBEEF, PSTRB=4'hF; then read 8'h04 → PREADY high in the first access cycle of each transfer, PRDATA=32'hDEADBEEF, PSLVERR=0.
- Wait states: wait_cfg=3; read 8'h04 → exactly 3 access cycles with PREADY=0, then PREADY=1 with PRDATA=32'hDEADBEEF; the PREADY=1 cycle after completion is not repeated.
- Partial strobe: write 8'h08 = 32'h11223344 with PSTRB=4'hF, then write 32'hAABBCCDD with PSTRB=4'b0101 → reading 8'h08 returns 32'h11BB33DD.
- Errors:
  - Write to PADDR=8'h80 (index 32, DEPTH=32) → PSLVERR=1 with PREADY.
  - Read of 8'h02 (misaligned) → PSLVERR=1, PRDATA=0.
  - Neither error changes memory contents.
- Reset mid-transfer: wait_cfg=5; assert PRESET during the 2nd wait cycle of a write to 8'h0C → PREADY=0 next cycle; a subsequent read of 8'h0C returns 0.
- Stats (APB_SLV_STATS_EN defined): after the first four scenarios → wr_cnt=3, rd_cnt=3, err_cnt=2.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a register word memory, with programmable wait states,
// byte-strobe writes and error responses. Optional counters under APB_SLV_STATS_EN.
module apb_slave_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [3:0]              wait_cfg,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
`ifdef APB_SLV_STATS_EN
  ,
  output logic [15:0]             wr_cnt,
  output logic [15:0]             rd_cnt,
  output logic [15:0]             err_cnt
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] a32;
    a32 = 32'(addr);
    return ((a32 & 32'(BYTES - 1)) != 32'd0) || ((a32 >> OFF_W) >= 32'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] a32;
    a32 = 32'(addr) >> OFF_W;
    return a32[IDX_W-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [BYTES-1:0]      strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      else         res[8*b +: 8] = old_w[8*b +: 8];
    end
    return res;
  endfunction

  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic                  r_write, w_write_nx;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nx;
  logic [BYTES-1:0]      r_strb, w_strb_nx;
  logic [3:0]            r_cnt, w_cnt_nx;
  logic                  r_pready, w_pready_nx;
  logic                  r_pslverr, w_pslverr_nx;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nx;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_write;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_resp_data;

  // In IDLE the response is computed from the live setup bus; afterwards from the latched copy.
  assign w_sel_addr  = (r_state == S_ACCESS) ? r_addr : PADDR;
  assign w_sel_write = (r_state == S_ACCESS) ? r_write : PWRITE;
  assign w_err       = addr_err(w_sel_addr);
  assign w_idx       = addr_idx(w_sel_addr);
  assign w_resp_data = (w_err || w_sel_write) ? '0 : r_mem[w_idx];

  // FSM state and registered response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_addr    <= w_addr_nx;
      r_write   <= w_write_nx;
      r_wdata   <= w_wdata_nx;
      r_strb    <= w_strb_nx;
      r_cnt     <= w_cnt_nx;
      r_pready  <= w_pready_nx;
      r_pslverr <= w_pslverr_nx;
      r_prdata  <= w_prdata_nx;
    end
  end

  // Next-state, wait countdown and response loading
  always_comb begin
    w_state_nx   = r_state;
    w_addr_nx    = r_addr;
    w_write_nx   = r_write;
    w_wdata_nx   = r_wdata;
    w_strb_nx    = r_strb;
    w_cnt_nx     = r_cnt;
    w_pready_nx  = r_pready;
    w_pslverr_nx = r_pslverr;
    w_prdata_nx  = r_prdata;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_state_nx  = S_ACCESS;
          w_addr_nx   = PADDR;
          w_write_nx  = PWRITE;
          w_wdata_nx  = PWDATA;
          w_strb_nx   = PSTRB;
          w_cnt_nx    = wait_cfg;
          w_pready_nx = (wait_cfg == 4'd0);
          if (wait_cfg == 4'd0) begin
            w_pslverr_nx = w_err;
            w_prdata_nx  = w_resp_data;
          end else begin
            w_pslverr_nx = 1'b0;
            w_prdata_nx  = '0;
          end
        end else if (PSEL && PENABLE) begin
          // Access phase with no setup: answer with an immediate error
          w_state_nx   = S_DONE;
          w_pready_nx  = 1'b1;
          w_pslverr_nx = 1'b1;
          w_prdata_nx  = '0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          w_state_nx   = S_IDLE;
          w_pready_nx  = 1'b0;
          w_pslverr_nx = 1'b0;
          w_prdata_nx  = '0;
        end else if (PENABLE && r_pready) begin
          w_mem_we     = r_write && !w_err;
          w_state_nx   = S_IDLE;
          w_pready_nx  = 1'b0;
          w_pslverr_nx = 1'b0;
          w_prdata_nx  = '0;
        end else if (PENABLE) begin
          w_cnt_nx    = r_cnt - 4'd1;
          w_pready_nx = (r_cnt == 4'd1);
          if (r_cnt == 4'd1) begin
            w_pslverr_nx = w_err;
            w_prdata_nx  = w_resp_data;
          end else begin
            w_pslverr_nx = r_pslverr;
            w_prdata_nx  = r_prdata;
          end
        end else begin
          w_state_nx = S_ACCESS;
        end
      end
      S_DONE: begin
        w_state_nx   = S_IDLE;
        w_pready_nx  = 1'b0;
        w_pslverr_nx = 1'b0;
        w_prdata_nx  = '0;
      end
      default: begin
        w_state_nx   = S_IDLE;
        w_pready_nx  = 1'b0;
        w_pslverr_nx = 1'b0;
        w_prdata_nx  = '0;
      end
    endcase
  end

  // Word memory with byte-lane writes on the completion edge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_idx] <= merge_strb(r_mem[w_idx], r_wdata, r_strb);
    end else begin
      r_mem[w_idx] <= r_mem[w_idx];
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

`ifdef APB_SLV_STATS_EN
  logic        w_xfer_end;
  logic [15:0] r_wr_cnt, r_rd_cnt, r_err_cnt;

  assign w_xfer_end = (r_state == S_ACCESS) && PSEL && PENABLE && r_pready;

  // Saturating transfer counters
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wr_cnt  <= 16'd0;
      r_rd_cnt  <= 16'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (w_xfer_end && !r_pslverr && r_write && (r_wr_cnt != 16'hFFFF))
        r_wr_cnt <= r_wr_cnt + 16'd1;
      else
        r_wr_cnt <= r_wr_cnt;
      if (w_xfer_end && !r_pslverr && !r_write && (r_rd_cnt != 16'hFFFF))
        r_rd_cnt <= r_rd_cnt + 16'd1;
      else
        r_rd_cnt <= r_rd_cnt;
      if (((w_xfer_end && r_pslverr) || (r_state == S_DONE)) && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
      else
        r_err_cnt <= r_err_cnt;
    end
  end

  assign wr_cnt  = r_wr_cnt;
  assign rd_cnt  = r_rd_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule
